// File: rtl/rv_pkg.sv
// Shared definitions for the front end: PC-select encodings, the canonical
// NOP instruction, and the fetch-stage state encoding.
package rv_pkg;

  // PC select encodings consumed by the PC mux
  localparam logic [1:0] PC_SEL_INC  = 2'b00;
  localparam logic [1:0] PC_SEL_BR   = 2'b01;
  localparam logic [1:0] PC_SEL_JMP  = 2'b10;
  localparam logic [1:0] PC_SEL_HOLD = 2'b11;

  // addi x0, x0, 0 -- the value decode sees when nothing valid is held
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DROP = 2'b10
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues one memory request per instruction over a
// valid/ready handshake, holds the returned word for decode, and drops
// wrong-path fetches when a branch/jump redirect is taken.
module fetch_stage
  import rv_pkg::*;
#(
  parameter int unsigned      ADDR_W    = 32,
  parameter int unsigned      INSTR_W   = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               redirect,
  output logic               fetch_hold,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               if_valid,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic               if_misalign,
  input  logic               id_ready
);

  fetch_state_t       state_q, state_d;
  logic               if_valid_q, if_valid_d;
  logic [ADDR_W-1:0]  if_pc_q, if_pc_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic               if_mis_q, if_mis_d;
  logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
  logic               req_mis_q, req_mis_d;

  logic buf_free;
  logic accept;
  logic load;

  // Handshake terms shared by the FSM and the output register
  always_comb begin
    buf_free       = !if_valid_q || id_ready;
    imem_req_valid = (state_q == IDLE) && buf_free && !redirect;
    imem_req_addr  = {pc_in[ADDR_W-1:2], 2'b00};
    accept         = imem_req_valid && imem_req_ready;
    fetch_hold     = !accept;
  end

  // Next-state logic: one request outstanding; redirect turns a pending fetch into a drop
  always_comb begin
    state_d   = state_q;
    req_pc_d  = req_pc_q;
    req_mis_d = req_mis_q;
    load      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = WAIT;
          req_pc_d  = pc_in;
          req_mis_d = |pc_in[1:0];
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          // A response coinciding with redirect is wrong-path and is discarded
          load    = !redirect;
          state_d = IDLE;
        end else if (redirect) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (imem_rsp_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register: load replaces, drain clears valid only, redirect flushes to NOP
  always_comb begin
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_mis_d   = if_mis_q;
    if (if_valid_q && id_ready) begin
      if_valid_d = 1'b0;
    end
    if (load) begin
      if_valid_d = 1'b1;
      if_pc_d    = req_pc_q;
      if_instr_d = imem_rsp_data;
      if_mis_d   = req_mis_q;
    end
    if (redirect) begin
      if_valid_d = 1'b0;
      if_instr_d = NOP_INSTR;
    end
  end

  // State and data registers; reset abandons any outstanding request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_instr_q <= NOP_INSTR;
      if_mis_q   <= 1'b0;
      req_pc_q   <= '0;
      req_mis_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_mis_q   <= if_mis_d;
      req_pc_q   <= req_pc_d;
      req_mis_q  <= req_mis_d;
    end
  end

  assign if_valid    = if_valid_q;
  assign if_pc       = if_pc_q;
  assign if_instr    = if_instr_q;
  assign if_misalign = if_mis_q;

endmodule
